// File: rtl/apb_fsm_controller_if.sv
// AHB-side pipeline inputs and registered APB outputs of the bridge's APB controller.
// The slave modport is the controller's view; master is the upstream/testbench view.
interface apb_fsm_controller_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SLAVES = 3
);
    logic                  valid;
    logic                  Hwrite;
    logic                  Hwritereg;
    logic [ADDR_WIDTH-1:0] Haddr;
    logic [ADDR_WIDTH-1:0] Haddr1;
    logic [ADDR_WIDTH-1:0] Haddr2;
    logic [DATA_WIDTH-1:0] Hwdata;
    logic [DATA_WIDTH-1:0] Hwdata1;
    logic [NUM_SLAVES-1:0] Pselx;
    logic [ADDR_WIDTH-1:0] Paddr;
    logic [DATA_WIDTH-1:0] Pwdata;
    logic                  Pwrite;
    logic                  Penable;
    logic                  Hreadyout;

    modport slave (
        input  valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1,
        output Pselx, Paddr, Pwdata, Pwrite, Penable, Hreadyout
    );

    modport master (
        output valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1,
        input  Pselx, Paddr, Pwdata, Pwrite, Penable, Hreadyout
    );
endinterface

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: turns AHB transfers into APB SETUP/ENABLE
// phases with registered outputs, stalling the AHB master through Hreadyout.
module apb_fsm_controller #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SLAVES = 3
) (
    input  logic                   Hclk,
    input  logic                   Hreset,
    apb_fsm_controller_if.slave    bus
);

    typedef enum logic [2:0] {
        StIdle, StWwait, StRead, StWrite, StWritep, StRenable, StWenable, StWenablep
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_SLAVES-1:0] pselx_q, pselx_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  penable_q, penable_d;
    logic                  hready_q, hready_d;

    // Each slave owns four 16 MB regions starting at 0x80 in the top address byte.
    function automatic logic [NUM_SLAVES-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [7:0] region;
        decode = '0;
        region = addr[ADDR_WIDTH-1 -: 8] - 8'h80;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (addr[ADDR_WIDTH-1] && region >= 8'(4 * i) && region < 8'(4 * (i + 1))) begin
                decode[i] = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q   <= StIdle;
            pselx_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pselx_q   <= pselx_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            hready_q  <= hready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pselx_d   = pselx_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;
        hready_d  = hready_q;

        case (state_q)
            StIdle, StRenable, StWenable: begin
                if (bus.valid && bus.Hwrite)       state_d = StWwait;
                else if (bus.valid)                state_d = StRead;
                else                               state_d = StIdle;
            end
            StWwait:    state_d = bus.valid ? StWritep : StWrite;
            StRead:     state_d = StRenable;
            StWrite:    state_d = bus.valid ? StWenablep : StWenable;
            StWritep:   state_d = StWenablep;
            StWenablep: begin
                if (!bus.Hwritereg)                state_d = StRead;
                else if (bus.valid)                state_d = StWritep;
                else                               state_d = StWrite;
            end
            default:    state_d = StIdle;
        endcase

        // Outputs are loaded on the edge that enters state_d.
        case (state_d)
            StIdle, StWwait: begin
                pselx_d   = '0;
                penable_d = 1'b0;
                hready_d  = 1'b1;
            end
            StRead: begin
                paddr_d   = bus.Haddr;
                pselx_d   = decode(bus.Haddr);
                pwrite_d  = 1'b0;
                penable_d = 1'b0;
                hready_d  = 1'b0;
            end
            StWrite, StWritep: begin
                // A write pipelined behind another lags one extra cycle in the AHB stream.
                if (state_q == StWenablep) begin
                    paddr_d  = bus.Haddr2;
                    pwdata_d = bus.Hwdata1;
                    pselx_d  = decode(bus.Haddr2);
                end else begin
                    paddr_d  = bus.Haddr1;
                    pwdata_d = bus.Hwdata;
                    pselx_d  = decode(bus.Haddr1);
                end
                pwrite_d  = 1'b1;
                penable_d = 1'b0;
                hready_d  = 1'b0;
            end
            default: begin
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end
        endcase
    end

    assign bus.Pselx     = pselx_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Penable   = penable_q;
    assign bus.Hreadyout = hready_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: directed scenarios plus randomized transfer groups checked
// against an expected APB transfer queue and per-cycle handshake schedule.
module tb_apb_fsm_controller;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NS = 3;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NS-1:0] sel;
    } xfer_t;

    logic Hclk = 1'b0;
    logic Hreset;
    always #5 Hclk = ~Hclk;

    apb_fsm_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

    apb_fsm_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    xfer_t         exp_q[$];
    xfer_t         mon_x;
    logic          mon_en    = 1'b0;
    logic          prev_pen  = 1'b0;
    logic          prev_w    = 1'b0;
    logic          prev_hr   = 1'b1;
    logic [NS-1:0] prev_sel  = '0;
    logic [AW-1:0] prev_addr = '0;

    // Upstream AHB slave interface: delayed copies of the address/data/direction.
    always @(posedge Hclk) begin
        bus.Haddr1    <= bus.Haddr;
        bus.Haddr2    <= bus.Haddr1;
        bus.Hwdata1   <= bus.Hwdata;
        bus.Hwritereg <= bus.Hwrite;
    end

    // Every ENABLE cycle must follow a matching SETUP and complete the oldest expected transfer.
    always @(negedge Hclk) begin
        if (mon_en && bus.Penable === 1'b1) begin
            checks++;
            if (prev_pen !== 1'b0 || prev_hr !== 1'b0 || prev_sel !== bus.Pselx ||
                prev_addr !== bus.Paddr || prev_w !== bus.Pwrite) begin
                errors++;
                $display("FAIL apb_setup: enable sel=%b addr=%h w=%b after pen=%b hr=%b sel=%b addr=%h w=%b, want setup pen=0 hr=0 same sel/addr/w",
                         bus.Pselx, bus.Paddr, bus.Pwrite, prev_pen, prev_hr, prev_sel,
                         prev_addr, prev_w);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL apb_unexpected: enable sel=%b addr=%h w=%b, want no transfer",
                         bus.Pselx, bus.Paddr, bus.Pwrite);
            end else begin
                mon_x = exp_q.pop_front();
                if (bus.Pwrite !== mon_x.w || bus.Paddr !== mon_x.a ||
                    bus.Pselx !== mon_x.sel || (mon_x.w && bus.Pwdata !== mon_x.d)) begin
                    errors++;
                    $display("FAIL apb_xfer: got w=%b addr=%h data=%h sel=%b want w=%b addr=%h data=%h sel=%b",
                             bus.Pwrite, bus.Paddr, bus.Pwdata, bus.Pselx,
                             mon_x.w, mon_x.a, mon_x.d, mon_x.sel);
                end
            end
        end
        prev_pen  = bus.Penable;
        prev_hr   = bus.Hreadyout;
        prev_sel  = bus.Pselx;
        prev_addr = bus.Paddr;
        prev_w    = bus.Pwrite;
    end

    function automatic logic [NS-1:0] sel_of(input logic [AW-1:0] a);
        int            top;
        logic [NS-1:0] one;
        top = int'(a[31:24]);
        one = 3'b001;
        if (top >= 'h80 && top <= 'h8B) return one << ((top - 'h80) / 4);
        return '0;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [7:0] top;
        top = 8'($urandom_range('h7E, 'h8D));
        return {top, 24'($urandom)};
    endfunction

    task automatic step();
        @(negedge Hclk);
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        bus.valid  = v;
        bus.Hwrite = w;
        bus.Haddr  = a;
        bus.Hwdata = d;
    endtask

    task automatic test_reset();
        Hreset = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        repeat (3) step();
        checks++;
        if ({bus.Pselx, bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Penable, bus.Hreadyout} !==
            {3'b000, 32'h0, 32'h0, 3'b001}) begin
            errors++;
            $display("FAIL reset_outputs: got sel=%b addr=%h data=%h w=%b en=%b hr=%b want all 0, hr=1",
                     bus.Pselx, bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Penable, bus.Hreadyout);
        end
        Hreset = 1'b0;
        mon_en = 1'b1;
        step();
        checks++;
        if ({bus.Pselx, bus.Penable, bus.Hreadyout} !== 5'b000_0_1) begin
            errors++;
            $display("FAIL reset_idle: got sel=%b en=%b hr=%b want 000 0 1",
                     bus.Pselx, bus.Penable, bus.Hreadyout);
        end
    endtask

    task automatic test_single_write();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = 32'h8000_0010;
        d = 32'h1234_5678;
        exp_q.push_back('{w: 1'b1, a: a, d: d, sel: 3'b001});
        step(); drive(1'b1, 1'b1, a, '0);
        step();
        checks++;
        if ({bus.Pselx, bus.Penable, bus.Hreadyout} !== 5'b000_0_1) begin
            errors++;
            $display("FAIL t1_wwait: got sel=%b en=%b hr=%b want 000 0 1",
                     bus.Pselx, bus.Penable, bus.Hreadyout);
        end
        drive(1'b0, 1'b1, '0, d);
        step();
        checks++;
        if ({bus.Pselx, bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Penable, bus.Hreadyout} !==
            {3'b001, a, d, 3'b100}) begin
            errors++;
            $display("FAIL t1_setup: got sel=%b addr=%h data=%h w=%b en=%b hr=%b want 001 %h %h 1 0 0",
                     bus.Pselx, bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Penable, bus.Hreadyout,
                     a, d);
        end
        step();
        checks++;
        if ({bus.Pselx, bus.Penable, bus.Hreadyout} !== 5'b001_1_1) begin
            errors++;
            $display("FAIL t1_enable: got sel=%b en=%b hr=%b want 001 1 1",
                     bus.Pselx, bus.Penable, bus.Hreadyout);
        end
        step();
        checks++;
        if ({bus.Pselx, bus.Penable, bus.Hreadyout} !== 5'b000_0_1) begin
            errors++;
            $display("FAIL t1_idle: got sel=%b en=%b hr=%b want 000 0 1",
                     bus.Pselx, bus.Penable, bus.Hreadyout);
        end
    endtask

    task automatic test_single_read();
        logic [AW-1:0] a;
        a = 32'h8400_0020;
        exp_q.push_back('{w: 1'b0, a: a, d: '0, sel: 3'b010});
        step(); drive(1'b1, 1'b0, a, '0);
        step();
        checks++;
        if ({bus.Pselx, bus.Paddr, bus.Pwrite, bus.Penable, bus.Hreadyout} !==
            {3'b010, a, 3'b000}) begin
            errors++;
            $display("FAIL t2_setup: got sel=%b addr=%h w=%b en=%b hr=%b want 010 %h 0 0 0",
                     bus.Pselx, bus.Paddr, bus.Pwrite, bus.Penable, bus.Hreadyout, a);
        end
        drive(1'b0, 1'b0, '0, '0);
        step();
        checks++;
        if ({bus.Pselx, bus.Penable, bus.Hreadyout} !== 5'b010_1_1) begin
            errors++;
            $display("FAIL t2_enable: got sel=%b en=%b hr=%b want 010 1 1",
                     bus.Pselx, bus.Penable, bus.Hreadyout);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a0, a1;
        a0 = 32'h8000_0000;
        a1 = 32'h8000_0004;
        exp_q.push_back('{w: 1'b1, a: a0, d: 32'hA, sel: 3'b001});
        exp_q.push_back('{w: 1'b1, a: a1, d: 32'hB, sel: 3'b001});
        step(); drive(1'b1, 1'b1, a0, '0);
        step(); drive(1'b1, 1'b1, a1, 32'hA);
        step();
        checks++;
        if ({bus.Paddr, bus.Pwdata, bus.Penable, bus.Hreadyout} !== {a0, 32'hA, 2'b00}) begin
            errors++;
            $display("FAIL t3_setup0: got addr=%h data=%h en=%b hr=%b want %h 0000000a 0 0",
                     bus.Paddr, bus.Pwdata, bus.Penable, bus.Hreadyout, a0);
        end
        drive(1'b0, 1'b1, '0, 32'hB);
        step();
        checks++;
        if ({bus.Penable, bus.Hreadyout} !== 2'b11) begin
            errors++;
            $display("FAIL t3_enable0: got en=%b hr=%b want 1 1", bus.Penable, bus.Hreadyout);
        end
        step();
        checks++;
        if ({bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Penable, bus.Hreadyout} !==
            {a1, 32'hB, 3'b100}) begin
            errors++;
            $display("FAIL t3_setup1: got addr=%h data=%h w=%b en=%b hr=%b want %h 0000000b 1 0 0",
                     bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Penable, bus.Hreadyout, a1);
        end
        step(); step();
    endtask

    task automatic test_write_then_read();
        logic [AW-1:0] a, b;
        a = 32'h8800_0008;
        b = 32'h8800_0010;
        exp_q.push_back('{w: 1'b1, a: a, d: 32'h5555_AAAA, sel: 3'b100});
        exp_q.push_back('{w: 1'b0, a: b, d: '0, sel: 3'b100});
        step(); drive(1'b1, 1'b1, a, '0);
        step(); drive(1'b0, 1'b1, '0, 32'h5555_AAAA);
        step(); drive(1'b1, 1'b0, b, 32'h5555_AAAA);
        step();
        checks++;
        if ({bus.Pselx, bus.Penable, bus.Hreadyout} !== 5'b100_1_1) begin
            errors++;
            $display("FAIL t4_wenable: got sel=%b en=%b hr=%b want 100 1 1",
                     bus.Pselx, bus.Penable, bus.Hreadyout);
        end
        step();
        checks++;
        if ({bus.Pselx, bus.Paddr, bus.Pwrite, bus.Penable, bus.Hreadyout} !==
            {3'b100, b, 3'b000}) begin
            errors++;
            $display("FAIL t4_rsetup: got sel=%b addr=%h w=%b en=%b hr=%b want 100 %h 0 0 0",
                     bus.Pselx, bus.Paddr, bus.Pwrite, bus.Penable, bus.Hreadyout, b);
        end
        drive(1'b0, 1'b0, '0, '0);
        step(); step();
    endtask

    task automatic test_invalid_addr();
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({bus.Pselx, bus.Penable, bus.Hreadyout} !== 5'b000_0_1) begin
                errors++;
                $display("FAIL t5_idle[%0d]: got sel=%b en=%b hr=%b want 000 0 1",
                         i, bus.Pselx, bus.Penable, bus.Hreadyout);
            end
            drive(1'b0, 1'b1, 32'h9000_0000, '0);
        end
    endtask

    task automatic test_reset_mid_transfer();
        step(); drive(1'b1, 1'b1, 32'h8400_0040, '0);
        step(); drive(1'b0, 1'b1, '0, 32'hDEAD_BEEF);
        step();
        checks++;
        if ({bus.Pselx, bus.Hreadyout} !== 4'b010_0) begin
            errors++;
            $display("FAIL t6_setup: got sel=%b hr=%b want 010 0", bus.Pselx, bus.Hreadyout);
        end
        Hreset = 1'b1;
        drive(1'b0, 1'b1, '0, '0);
        step();
        checks++;
        if ({bus.Pselx, bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Penable, bus.Hreadyout} !==
            {3'b000, 32'h0, 32'h0, 3'b001}) begin
            errors++;
            $display("FAIL t6_reset: got sel=%b addr=%h data=%h w=%b en=%b hr=%b want all 0, hr=1",
                     bus.Pselx, bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Penable, bus.Hreadyout);
        end
        Hreset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus.Penable, bus.Hreadyout} !== 2'b01) begin
                errors++;
                $display("FAIL t6_no_enable[%0d]: got en=%b hr=%b want 0 1",
                         i, bus.Penable, bus.Hreadyout);
            end
        end
    endtask

    // Groups: 0 write, 1 read, 2 back-to-back writes, 3 write then stalled read.
    task automatic test_random();
        int            kind, len, gap;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [5:0]    gv, gw, hr, pe;
        logic [AW-1:0] ga[6];
        logic [DW-1:0] gd[6];
        for (int g = 0; g < 40; g++) begin
            kind = $urandom_range(0, 3);
            a0 = rand_addr();
            a1 = rand_addr();
            d0 = $urandom;
            d1 = $urandom;
            for (int s = 0; s < 6; s++) begin
                ga[s] = rand_addr();
                gd[s] = d0;
            end
            ga[0] = a0;
            case (kind)
                0: begin
                    len = 4; gv = 6'b000001; gw = 6'b001111; hr = 6'b001011; pe = 6'b001000;
                    exp_q.push_back('{w: 1'b1, a: a0, d: d0, sel: sel_of(a0)});
                end
                1: begin
                    len = 3; gv = 6'b000001; gw = 6'b000000; hr = 6'b000101; pe = 6'b000100;
                    exp_q.push_back('{w: 1'b0, a: a0, d: '0, sel: sel_of(a0)});
                end
                2: begin
                    len = 6; gv = 6'b000011; gw = 6'b111111; hr = 6'b101011; pe = 6'b101000;
                    ga[1] = a1;
                    for (int s = 2; s < 6; s++) gd[s] = d1;
                    exp_q.push_back('{w: 1'b1, a: a0, d: d0, sel: sel_of(a0)});
                    exp_q.push_back('{w: 1'b1, a: a1, d: d1, sel: sel_of(a1)});
                end
                default: begin
                    len = 6; gv = 6'b001101; gw = 6'b000011; hr = 6'b101011; pe = 6'b101000;
                    ga[2] = a1;
                    ga[3] = a1;
                    exp_q.push_back('{w: 1'b1, a: a0, d: d0, sel: sel_of(a0)});
                    exp_q.push_back('{w: 1'b0, a: a1, d: '0, sel: sel_of(a1)});
                end
            endcase
            for (int s = 0; s < len; s++) begin
                step();
                checks++;
                if ({bus.Hreadyout, bus.Penable} !== {hr[s], pe[s]}) begin
                    errors++;
                    $display("FAIL rand_handshake g%0d k%0d s%0d: got hr=%b en=%b want hr=%b en=%b",
                             g, kind, s, bus.Hreadyout, bus.Penable, hr[s], pe[s]);
                end
                drive(gv[s], gw[s], ga[s], gd[s]);
            end
            gap = $urandom_range(1, 3);
            for (int s = 0; s < gap; s++) begin
                step();
                checks++;
                if ({bus.Pselx, bus.Penable, bus.Hreadyout} !== 5'b000_0_1) begin
                    errors++;
                    $display("FAIL rand_idle g%0d: got sel=%b en=%b hr=%b want 000 0 1",
                             g, bus.Pselx, bus.Penable, bus.Hreadyout);
                end
                drive(1'b0, gw[len-1], rand_addr(), $urandom);
            end
        end
    endtask

    task automatic test_drain();
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected transfers never seen, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_write_then_read();
        test_invalid_addr();
        test_reset_mid_transfer();
        test_random();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
